// File: rtl/hex_7seg_pkg.sv
// Shared constants and helpers for the hex 7-segment scan driver.
//   SEG_0..SEG_F : active-high {a,b,c,d,e,f,g} patterns for each hex digit
//   hex_to_seg   : nibble -> pattern
//   clog2        : ceiling log2, usable in parameter/localparam expressions
package hex_7seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_7seg_lut.sv
// Combinational hex nibble -> active-high abcdefg decoder.
//   nibble_i : hex digit
//   seg_o    : {a,b,c,d,e,f,g}
module hex_7seg_lut
  import hex_7seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/hex_7seg_scan_driver.sv
// Time-multiplexed hex 7-segment display driver.
//   clk, reset_n : clock, async active-low reset
//   enable       : 1 scans, 0 darkens display and freezes counters
//   load         : capture value/dots into shadow registers
//   value, dots  : packed nibbles / decimal points, digit 0 least significant
//   blank_lz     : suppress leading zeros
//   seg, dp, an  : registered display pins (polarity set by *_ACT_LOW)
//   digit_idx    : digit currently scanned
//   frame_done   : 1-cycle pulse after the last digit wraps to digit 0
module hex_7seg_scan_driver
  import hex_7seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit AN_ACT_LOW   = 1'b0,
  localparam int IDXW = (DIGITS > 1) ? clog2(DIGITS) : 1,
  localparam int CW   = clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic [IDXW-1:0]       digit_idx,
  output logic                  frame_done
);

  logic [4*DIGITS-1:0] shadow_val_q;
  logic [DIGITS-1:0]   shadow_dot_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                fd_q;
  logic [3:0]          nib_q;
  logic                dot_q, blank_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                slot_start, slot_end, idx_last;
  logic [DIGITS-1:0]   zero_above;
  logic [3:0]          cur_nib;
  logic                cur_dot, cur_blank;
  logic [6:0]          lut_seg;

  assign slot_start = (cnt_q == '0);
  assign slot_end   = (cnt_q == CW'(REFRESH_DIV - 1));
  assign idx_last   = (idx_q == IDXW'(DIGITS - 1));

  // zero_above[i]: every nibble from i up to the top digit is zero
  always_comb begin
    zero_above = '0;
    for (int i = 0; i < DIGITS; i++)
      zero_above[i] = ((shadow_val_q >> (4 * i)) == '0);
  end

  // At slot start the digit is taken straight from the shadow (and latched on
  // the same edge) so the output register sees it with one cycle of latency.
  always_comb begin
    if (slot_start) begin
      cur_nib   = shadow_val_q[{idx_q, 2'b00} +: 4];
      cur_dot   = shadow_dot_q[idx_q];
      cur_blank = blank_lz && (idx_q != '0) && zero_above[idx_q];
    end else begin
      cur_nib   = nib_q;
      cur_dot   = dot_q;
      cur_blank = blank_q;
    end
  end

  hex_7seg_lut u_lut (
    .nibble_i (cur_nib),
    .seg_o    (lut_seg)
  );

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = idx_last ? '0 : idx_q + 1'b1;
    an_d = '0;
    if (int'(cnt_q) >= BLANK_CYCLES) an_d[idx_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_val_q <= '0;
      shadow_dot_q <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      fd_q         <= 1'b0;
      nib_q        <= '0;
      dot_q        <= 1'b0;
      blank_q      <= 1'b0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= '0;
    end else begin
      if (load) begin
        shadow_val_q <= value;
        shadow_dot_q <= dots;
      end
      if (enable) begin
        cnt_q <= cnt_d;
        idx_q <= idx_d;
        fd_q  <= slot_end && idx_last;
        if (slot_start) begin
          nib_q   <= cur_nib;
          dot_q   <= cur_dot;
          blank_q <= cur_blank;
        end
        seg_q <= cur_blank ? 7'b0 : lut_seg;
        dp_q  <= cur_dot;
        an_q  <= an_d;
      end else begin
        fd_q  <= 1'b0;
        seg_q <= '0;
        dp_q  <= 1'b0;
        an_q  <= '0;
      end
    end
  end

  // Polarity is applied only at the pins; internal state stays active-high.
  assign seg        = seg_q ^ {7{SEG_ACT_LOW}};
  assign dp         = dp_q ^ SEG_ACT_LOW;
  assign an         = an_q ^ {DIGITS{AN_ACT_LOW}};
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule
